// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 stream driver.
// Defaults assume a 50 MHz clock.
package ws2812_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_LATCH = 3'd4
    } state_e;

    localparam int BITS_GRB  = 24;
    localparam int BITS_GRBW = 32;

    localparam int DEF_T0H   = 20;
    localparam int DEF_T0L   = 40;
    localparam int DEF_T1H   = 40;
    localparam int DEF_T1L   = 20;
    localparam int DEF_T_RST = 4096;

    function automatic int max_timing(input int a, input int b, input int c,
                                      input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/ws2812_phase_timer.sv
// Loadable down-counter shared by every line phase (reset, high, low, latch).
// expire is high in the last cycle of a phase of load_val cycles.
module ws2812_phase_timer
    import ws2812_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expire
);

    logic [CW-1:0] cnt_q, cnt_d;

    // load_val is always >= 1, so loading load_val-1 yields exactly load_val cycles
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val - CW'(1);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/ws2812_stream_driver.sv
// Single-wire WS2812 driver fed by a valid/ready pixel stream.
// One holding register decouples upstream from the serialiser; missing pixels go out black.
module ws2812_stream_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 512,
    parameter int BITS_PER_LED = BITS_GRB,
    parameter int T0H          = DEF_T0H,
    parameter int T0L          = DEF_T0L,
    parameter int T1H          = DEF_T1H,
    parameter int T1L          = DEF_T1L,
    parameter int T_RST        = DEF_T_RST
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    show,
    input  logic [BITS_PER_LED-1:0] pix_data,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic                    dout,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun
);

    localparam int CW = $clog2(max_timing(T_RST, T0H, T0L, T1H, T1L) + 1);
    localparam int LW = $clog2(NUM_LEDS + 1);
    localparam int BW = $clog2(BITS_PER_LED);
    localparam int MSB = BITS_PER_LED - 1;

    localparam logic [LW-1:0] LAST_LED  = LW'(NUM_LEDS - 1);
    localparam logic [LW:0]   NUM_SLOTS = (LW+1)'(NUM_LEDS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_LED - 1);
    localparam logic [CW-1:0] T0H_V     = CW'(T0H);
    localparam logic [CW-1:0] T0L_V     = CW'(T0L);
    localparam logic [CW-1:0] T1H_V     = CW'(T1H);
    localparam logic [CW-1:0] T1L_V     = CW'(T1L);
    localparam logic [CW-1:0] T_RST_V   = CW'(T_RST);

    generate
        if (T0H < 1 || T0L < 1 || T1H < 1 || T1L < 1 || T_RST < 1) begin : g_bad_timing
            $error("ws2812_stream_driver: every timing parameter must be at least 1");
        end
        if (NUM_LEDS < 1 || BITS_PER_LED < 2) begin : g_bad_size
            $error("ws2812_stream_driver: NUM_LEDS must be >= 1 and BITS_PER_LED >= 2");
        end
    endgenerate

    state_e                  state_q, state_d;
    logic [BITS_PER_LED-1:0] hold_data_q, hold_data_d;
    logic                    hold_full_q, hold_full_d;
    logic [BITS_PER_LED-1:0] shreg_q, shreg_d;
    logic [BW-1:0]           bit_idx_q, bit_idx_d;
    logic [LW-1:0]           led_idx_q, led_idx_d;
    logic [LW-1:0]           slot_cnt_q, slot_cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    underrun_q, underrun_d;
    logic                    dout_q, dout_d;

    logic                    load_px;
    logic                    frame_start;
    logic                    timer_load;
    logic [CW-1:0]           timer_val;
    logic                    timer_expire;
    logic                    xfer;
    logic [BITS_PER_LED-1:0] load_word;
    logic [LW:0]             slot_claim;

    ws2812_phase_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (timer_expire)
    );

    assign load_word = hold_full_q ? hold_data_q : '0;

    // Count an underrun claimed this cycle too, so a load-cycle transfer can never overrun the frame
    assign slot_claim = {1'b0, slot_cnt_q} + (LW+1)'(load_px && !hold_full_q);
    assign pix_ready  = busy_q && !hold_full_q && (slot_claim < NUM_SLOTS);
    assign xfer       = pix_valid && pix_ready;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        led_idx_d   = led_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load_px     = 1'b0;
        frame_start = 1'b0;
        timer_load  = 1'b0;
        timer_val   = T_RST_V;
        case (state_q)
            S_IDLE: begin
                if (show) begin
                    state_d     = S_RST;
                    busy_d      = 1'b1;
                    bit_idx_d   = '0;
                    led_idx_d   = '0;
                    frame_start = 1'b1;
                    timer_load  = 1'b1;
                    timer_val   = T_RST_V;
                end
            end
            S_RST: begin
                if (timer_expire) begin
                    load_px    = 1'b1;
                    shreg_d    = load_word;
                    state_d    = S_HI;
                    timer_load = 1'b1;
                    timer_val  = load_word[MSB] ? T1H_V : T0H_V;
                end
            end
            S_HI: begin
                if (timer_expire) begin
                    state_d    = S_LO;
                    timer_load = 1'b1;
                    timer_val  = shreg_q[MSB] ? T1L_V : T0L_V;
                end
            end
            S_LO: begin
                if (timer_expire) begin
                    timer_load = 1'b1;
                    if (bit_idx_q < LAST_BIT) begin
                        shreg_d   = {shreg_q[MSB-1:0], 1'b0};
                        bit_idx_d = bit_idx_q + BW'(1);
                        state_d   = S_HI;
                        timer_val = shreg_q[MSB-1] ? T1H_V : T0H_V;
                    end else if (led_idx_q < LAST_LED) begin
                        led_idx_d = led_idx_q + LW'(1);
                        bit_idx_d = '0;
                        load_px   = 1'b1;
                        shreg_d   = load_word;
                        state_d   = S_HI;
                        timer_val = load_word[MSB] ? T1H_V : T0H_V;
                    end else begin
                        state_d   = S_LATCH;
                        timer_val = T_RST_V;
                    end
                end
            end
            S_LATCH: begin
                if (timer_expire) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register and slot accounting; a same-cycle transfer only ever fills hold for the next pixel
    always_comb begin
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        if (load_px) begin
            if (hold_full_q) hold_full_d = 1'b0;
            else             underrun_d  = 1'b1;
        end
        if (xfer) begin
            hold_data_d = pix_data;
            hold_full_d = 1'b1;
        end
        slot_cnt_d = slot_cnt_q + LW'(underrun_d) + LW'(xfer);
        if (frame_start) slot_cnt_d = '0;
        dout_d = (state_q == S_HI);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            led_idx_q   <= '0;
            slot_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            led_idx_q   <= led_idx_d;
            slot_cnt_q  <= slot_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            dout_q      <= dout_d;
        end
    end

    assign dout     = dout_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule
